// File: rtl/mux_select_arbiter_pkg.sv
// Shared constants for the 2:1 operand-mux arbiter: select encodings and the
// output-register occupancy states.
package mux_select_arbiter_pkg;

  localparam logic SEL_IN1 = 1'b0;
  localparam logic SEL_IN2 = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mux_select_arbiter_rr_grant_2.sv
// Two-way round-robin grant, combinational (0 cycles); the caller gates the
// grant with its own load condition, so no backpressure is handled here.
module mux_select_arbiter_rr_grant_2
  import mux_select_arbiter_pkg::*;
(
  input  logic valid_1_i,
  input  logic valid_2_i,
  input  logic prio_i,
  output logic grant_1_o,
  output logic grant_2_o,
  output logic any_grant_o,
  output logic win_idx_o,
  output logic prio_nxt_o
);

  always_comb begin
    grant_1_o = 1'b0;
    grant_2_o = 1'b0;
    if (valid_1_i && valid_2_i) begin
      grant_1_o = (prio_i == SEL_IN1);
      grant_2_o = (prio_i == SEL_IN2);
    end else begin
      grant_1_o = valid_1_i;
      grant_2_o = valid_2_i;
    end
  end

  assign any_grant_o = grant_1_o | grant_2_o;
  assign win_idx_o   = grant_2_o ? SEL_IN2 : SEL_IN1;
  // The loser of this grant is preferred next; with no grant the priority holds.
  assign prio_nxt_o  = any_grant_o ? ~win_idx_o : prio_i;

endmodule

// File: rtl/mux_select_arbiter.sv
// Round-robin 2:1 arbiter with a one-entry output register, 1-cycle latency; input
// ready drops while the held item is unconsumed. MUX_ARB_STATS_EN adds grant counters.
module mux_select_arbiter
  import mux_select_arbiter_pkg::*;
#(
  parameter int DATA_W = 8
`ifdef MUX_ARB_STATS_EN
  ,
  parameter int CNT_W  = 8
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_1,
  input  logic [DATA_W-1:0] in_data_1,
  output logic              in_ready_1,
  input  logic              in_valid_2,
  input  logic [DATA_W-1:0] in_data_2,
  output logic              in_ready_2,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              select
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  grant_cnt_1,
  output logic [CNT_W-1:0]  grant_cnt_2
`endif
);

  arb_state_e        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              sel_q, sel_d;
  logic              prio_q, prio_d;

  logic load;
  logic grant_1, grant_2, any_grant, win_idx, prio_nxt;

  mux_select_arbiter_rr_grant_2 u_rr_grant (
    .valid_1_i   (in_valid_1),
    .valid_2_i   (in_valid_2),
    .prio_i      (prio_q),
    .grant_1_o   (grant_1),
    .grant_2_o   (grant_2),
    .any_grant_o (any_grant),
    .win_idx_o   (win_idx),
    .prio_nxt_o  (prio_nxt)
  );

  assign load = (state_q == ST_EMPTY) || out_ready;

  // Ready is masked during reset so no requester sees a transfer that reset discards.
  assign in_ready_1 = load & grant_1 & ~reset;
  assign in_ready_2 = load & grant_2 & ~reset;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    prio_d  = prio_q;
    if (load) begin
      if (any_grant) begin
        state_d = ST_FULL;
        data_d  = grant_2 ? in_data_2 : in_data_1;
        sel_d   = win_idx;
        prio_d  = prio_nxt;
      end else begin
        state_d = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      sel_q   <= SEL_IN1;
      prio_q  <= SEL_IN1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      prio_q  <= prio_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign select    = sel_q;

`ifdef MUX_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_1_q, cnt_1_d;
  logic [CNT_W-1:0] cnt_2_q, cnt_2_d;

  // Counters saturate at all-ones rather than wrapping.
  always_comb begin
    cnt_1_d = cnt_1_q;
    cnt_2_d = cnt_2_q;
    if (in_ready_1 && (cnt_1_q != '1)) cnt_1_d = cnt_1_q + CNT_W'(1);
    if (in_ready_2 && (cnt_2_q != '1)) cnt_2_d = cnt_2_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_1_q <= '0;
      cnt_2_q <= '0;
    end else begin
      cnt_1_q <= cnt_1_d;
      cnt_2_q <= cnt_2_d;
    end
  end

  assign grant_cnt_1 = cnt_1_q;
  assign grant_cnt_2 = cnt_2_q;
`endif

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Directed bench for mux_select_arbiter; stats checks run when MUX_ARB_STATS_EN is defined.
module tb_mux_select_arbiter;

  logic       clk;
  logic       reset;
  logic       in_valid_1, in_valid_2;
  logic [7:0] in_data_1, in_data_2;
  logic       in_ready_1, in_ready_2;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       select;
`ifdef MUX_ARB_STATS_EN
  logic [1:0] grant_cnt_1, grant_cnt_2;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  mux_select_arbiter #(
    .DATA_W(8)
`ifdef MUX_ARB_STATS_EN
    ,
    .CNT_W(2)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid_1 (in_valid_1),
    .in_data_1  (in_data_1),
    .in_ready_1 (in_ready_1),
    .in_valid_2 (in_valid_2),
    .in_data_2  (in_data_2),
    .in_ready_2 (in_ready_2),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .select     (select)
`ifdef MUX_ARB_STATS_EN
    ,
    .grant_cnt_1(grant_cnt_1),
    .grant_cnt_2(grant_cnt_2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v1, input logic [7:0] d1,
                       input logic v2, input logic [7:0] d2, input logic ordy);
    in_valid_1 = v1;
    in_data_1  = d1;
    in_valid_2 = v2;
    in_data_2  = d2;
    out_ready  = ordy;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic s);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".out_data"},  {24'd0, out_data},  {24'd0, d});
    chk({tag, ".select"},    {31'd0, select},    {31'd0, s});
  endtask

  logic [7:0] exp_d3 [4];
  logic       exp_s3 [4];

  initial begin
    exp_d3 = '{8'h22, 8'h11, 8'h22, 8'h11};
    exp_s3 = '{1'b1, 1'b0, 1'b1, 1'b0};

    // 1: reset with both requesters valid
    reset = 1'b1;
    drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    tick();
    tick();
    chk_out("rst", 1'b0, 8'h00, 1'b0);
    chk("rst.in_ready_1", {31'd0, in_ready_1}, 32'd0);
    chk("rst.in_ready_2", {31'd0, in_ready_2}, 32'd0);

    // 2: lone requester 1 wins, prio moves to input 2
    reset = 1'b0;
    drive(1'b1, 8'hA5, 1'b0, 8'h00, 1'b1);
    chk("t2.in_ready_1", {31'd0, in_ready_1}, 32'd1);
    chk("t2.in_ready_2", {31'd0, in_ready_2}, 32'd0);
    tick();
    chk_out("t2", 1'b1, 8'hA5, 1'b0);

    // 3: both valid; input 2 is preferred first because input 1 just won
    drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out($sformatf("t3[%0d]", i), 1'b1, exp_d3[i], exp_s3[i]);
    end

    // 4: backpressure freezes the held item (11, sel 0) and drops both readies
    drive(1'b1, 8'h33, 1'b1, 8'h44, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t4[%0d].in_ready_1", i), {31'd0, in_ready_1}, 32'd0);
      chk($sformatf("t4[%0d].in_ready_2", i), {31'd0, in_ready_2}, 32'd0);
      tick();
      chk_out($sformatf("t4[%0d]", i), 1'b1, 8'h11, 1'b0);
    end
    drive(1'b1, 8'h33, 1'b1, 8'h44, 1'b1);
    chk("t4.rel.in_ready_2", {31'd0, in_ready_2}, 32'd1);
    chk("t4.rel.in_ready_1", {31'd0, in_ready_1}, 32'd0);
    tick();
    chk_out("t4.rel", 1'b1, 8'h44, 1'b1);

    // FULL -> EMPTY with no requester: data/select hold
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick();
    chk_out("empty", 1'b0, 8'h44, 1'b1);

    // 5: reset while FULL and stalled; prio returns to input 1
    drive(1'b1, 8'h55, 1'b0, 8'h00, 1'b1);
    tick();
    chk_out("t5.load", 1'b1, 8'h55, 1'b0);
    reset = 1'b1;
    drive(1'b1, 8'h66, 1'b1, 8'h77, 1'b0);
    tick();
    chk_out("t5.rst", 1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    drive(1'b1, 8'h66, 1'b1, 8'h77, 1'b1);
    tick();
    chk_out("t5.first", 1'b1, 8'h66, 1'b0);
    tick();
    chk_out("t5.second", 1'b1, 8'h77, 1'b1);

`ifdef MUX_ARB_STATS_EN
    // 6: 2-bit counter saturates after 5 grants to input 1
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick();
    reset = 1'b0;
    chk("t6.cnt1.rst", {30'd0, grant_cnt_1}, 32'd0);
    drive(1'b1, 8'h01, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    chk("t6.cnt1.sat", {30'd0, grant_cnt_1}, 32'd3);
    chk("t6.cnt2", {30'd0, grant_cnt_2}, 32'd0);
    drive(1'b0, 8'h00, 1'b1, 8'h02, 1'b1);
    tick();
    chk("t6.cnt2.one", {30'd0, grant_cnt_2}, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
